// File: rtl/spi_flash_responder_pkg.sv
// Shared types and constants for the SPI flash responder.
package spi_flash_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    IGNORE
  } state_e;

  localparam logic [7:0] CmdRead     = 8'h03;
  localparam logic [7:0] CmdFastRead = 8'h0B;
  localparam int         AddrBits    = 24;
  localparam logic [7:0] FillByte    = 8'hFF;

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Synchronizes the SPI pins into clk_i and derives one-cycle edge pulses.
module spi_flash_responder_sync #(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sck_i,
  input  logic csb_i,
  input  logic sd_i,
  output logic sd_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic csb_fall_o,
  output logic csb_rise_o
);

  logic [SyncStages-1:0] sck_q, csb_q, sd_q;
  logic                  sck_prev_q, csb_prev_q;

  // csb resets high so leaving reset never looks like a select.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_q      <= '0;
      csb_q      <= '1;
      sd_q       <= '0;
      sck_prev_q <= 1'b0;
      csb_prev_q <= 1'b1;
    end else begin
      sck_q[0] <= sck_i;
      csb_q[0] <= csb_i;
      sd_q[0]  <= sd_i;
      for (int i = 1; i < SyncStages; i++) begin
        sck_q[i] <= sck_q[i-1];
        csb_q[i] <= csb_q[i-1];
        sd_q[i]  <= sd_q[i-1];
      end
      sck_prev_q <= sck_q[SyncStages-1];
      csb_prev_q <= csb_q[SyncStages-1];
    end
  end

  assign sd_o       = sd_q[SyncStages-1];
  assign sck_rise_o =  sck_q[SyncStages-1] & ~sck_prev_q;
  assign sck_fall_o = ~sck_q[SyncStages-1] &  sck_prev_q;
  assign csb_fall_o = ~csb_q[SyncStages-1] &  csb_prev_q;
  assign csb_rise_o =  csb_q[SyncStages-1] & ~csb_prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// Read-only SPI flash emulator: READ (0x03) streams bytes from a byte memory port.
// Define SPI_FLASH_RESP_FAST_READ_EN to also accept FAST_READ (0x0B) with 8 dummy clocks.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int AddrWidth  = 16,
  parameter int SyncStages = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 spi_sck_i,
  input  logic                 spi_csb_i,
  input  logic                 spi_sd_i,
  output logic                 spi_sd_o,
  output logic                 spi_sd_en_o,
  output logic                 mem_req_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  input  logic                 mem_rvalid_i,
  input  logic [7:0]           mem_rdata_i,
  output logic                 busy_o,
  output logic                 underrun_o
);

  localparam logic [AddrWidth-1:0] AddrOne = 1;

  logic sck_rise, sck_fall, csb_fall, csb_rise, sd_s;

  spi_flash_responder_sync #(.SyncStages(SyncStages)) u_sync (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .sck_i      (spi_sck_i),
    .csb_i      (spi_csb_i),
    .sd_i       (spi_sd_i),
    .sd_o       (sd_s),
    .sck_rise_o (sck_rise),
    .sck_fall_o (sck_fall),
    .csb_fall_o (csb_fall),
    .csb_rise_o (csb_rise)
  );

  state_e               state_q;
  logic [4:0]           cnt_q;
  logic [2:0]           bit_q;
  logic [7:0]           cmd_q, shift_q, buf_q;
  logic [AddrWidth-1:0] addr_q, fetch_addr_q, mem_addr_q;
  logic                 buf_valid_q, pend_q, stale_q, need_q;
  logic                 mem_req_q, sd_q, sd_en_q, underrun_q;

  logic [7:0]           cmd_d, out_byte;
  logic [AddrWidth-1:0] addr_d;

  assign cmd_d    = {cmd_q[6:0], sd_s};
  assign addr_d   = {addr_q[AddrWidth-2:0], sd_s};
  assign out_byte = buf_valid_q ? buf_q : FillByte;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      cmd_q        <= '0;
      shift_q      <= '0;
      buf_q        <= '0;
      addr_q       <= '0;
      fetch_addr_q <= '0;
      mem_addr_q   <= '0;
      buf_valid_q  <= 1'b0;
      pend_q       <= 1'b0;
      stale_q      <= 1'b0;
      need_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      sd_q         <= 1'b0;
      sd_en_q      <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      mem_req_q <= 1'b0;
      if (mem_rvalid_i) begin
        pend_q  <= 1'b0;
        stale_q <= 1'b0;
      end
      if (csb_rise) begin
        // A read still in flight belongs to the aborted transaction; drop its data.
        state_q     <= IDLE;
        sd_q        <= 1'b0;
        sd_en_q     <= 1'b0;
        need_q      <= 1'b0;
        buf_valid_q <= 1'b0;
        stale_q     <= pend_q & ~mem_rvalid_i;
      end else begin
        case (state_q)
          IDLE: if (csb_fall) begin
            state_q    <= CMD;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
          end
          CMD: if (sck_rise) begin
            cmd_q <= cmd_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_q <= '0;
              if (cmd_d == CmdRead) state_q <= ADDR;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
              else if (cmd_d == CmdFastRead) state_q <= ADDR;
`endif
              else state_q <= IGNORE;
            end
          end
          ADDR: if (sck_rise) begin
            addr_q <= addr_d;
            cnt_q  <= cnt_q + 5'd1;
            if (cnt_q == 5'(AddrBits - 1)) begin
              cnt_q <= '0;
              bit_q <= '0;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
              state_q <= (cmd_q == CmdFastRead) ? DUMMY : DATA;
`else
              state_q <= DATA;
`endif
              if (!pend_q) begin
                mem_req_q    <= 1'b1;
                mem_addr_q   <= addr_d;
                fetch_addr_q <= addr_d + AddrOne;
                pend_q       <= 1'b1;
              end else begin
                need_q       <= 1'b1;
                fetch_addr_q <= addr_d;
              end
            end
          end
`ifdef SPI_FLASH_RESP_FAST_READ_EN
          DUMMY: if (sck_rise) begin
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_q   <= '0;
              state_q <= DATA;
            end
          end
`endif
          DATA: begin
            // One outstanding read and a one-entry buffer: fetch only into an empty slot.
            if (need_q && !pend_q && !buf_valid_q) begin
              mem_req_q    <= 1'b1;
              mem_addr_q   <= fetch_addr_q;
              fetch_addr_q <= fetch_addr_q + AddrOne;
              pend_q       <= 1'b1;
              need_q       <= 1'b0;
            end
            if (sck_fall) begin
              bit_q   <= bit_q + 3'd1;
              sd_en_q <= 1'b1;
              if (bit_q == 3'd0) begin
                sd_q        <= out_byte[7];
                shift_q     <= {out_byte[6:0], 1'b0};
                buf_valid_q <= 1'b0;
                need_q      <= 1'b1;
                if (!buf_valid_q) underrun_q <= 1'b1;
              end else begin
                sd_q    <= shift_q[7];
                shift_q <= {shift_q[6:0], 1'b0};
              end
            end
          end
          IGNORE: ;
          default: state_q <= IDLE;
        endcase
        if (mem_rvalid_i && !stale_q && (state_q == DATA || state_q == DUMMY)) begin
          buf_q       <= mem_rdata_i;
          buf_valid_q <= 1'b1;
        end
      end
    end
  end

  assign spi_sd_o    = sd_q;
  assign spi_sd_en_o = sd_en_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = mem_addr_q;
  assign busy_o      = (state_q != IDLE);
  assign underrun_o  = underrun_q;

endmodule
